// File: rtl/abr_prim_ext_reg_hs.sv
// Req/ack handshake back-end for one external CSR: turns slice write/read strobes
// into agent transactions and caches the result on d. Optional abort timer: ABR_EXT_REG_HS_TIMEOUT_EN.
module abr_prim_ext_reg_hs #(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          qe,
    input  logic [DW-1:0] q,
    input  logic          qre,
    output logic [DW-1:0] d,
    output logic          hw_req,
    output logic          hw_we,
    output logic [DW-1:0] hw_wdata,
    input  logic          hw_ack,
    input  logic [DW-1:0] hw_rdata,
    output logic          busy,
    output logic          err,
    input  logic          err_clr,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t state;
    logic   drop;
    logic   to_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // A strobe is lost if it collides with an outstanding transaction, or a read
    // arrives together with a write while idle (the write takes priority).
    assign drop = (state == IDLE) ? (qe && qre) : (qe || qre);

`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Abort on the cycle that would bring the wait count to TIMEOUT_CYCLES; an ack wins.
    assign to_hit = (state != IDLE) && !hw_ack && (cnt == TERM);
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            d        <= '0;
            hw_req   <= 1'b0;
            hw_we    <= 1'b0;
            hw_wdata <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
            timeout  <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (drop || to_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (qe) begin
                        hw_wdata <= q;
                        hw_we    <= 1'b1;
                        hw_req   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WR;
`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end else if (qre) begin
                        hw_we  <= 1'b0;
                        hw_req <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RD;
`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
                        cnt    <= '0;
`endif
                    end
                end
                WR, RD: begin
                    if (hw_ack) begin
                        d      <= (state == WR) ? hw_wdata : hw_rdata;
                        state  <= IDLE;
                        hw_req <= 1'b0;
                        busy   <= 1'b0;
`ifdef ABR_EXT_REG_HS_TIMEOUT_EN
                    end else if (to_hit) begin
                        if (state == RD) begin
                            d <= '1;
                        end
                        state   <= IDLE;
                        hw_req  <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    hw_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
